// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch and sequencing unit. Owns the program counter, drives the
// instruction-memory address, and hands each fetched 9-bit instruction (or a
// bubble) to the control decoder. It redirects on taken branches, stops on the
// halt word, and counts RUN cycles for the test harness.
//
// Parameters
//   PC_W        program counter / instruction-memory address width
//   CNT_W       run-cycle counter width
//
// Ports
//   Clk         in   single clock, rising-edge
//   Reset       in   asynchronous, active-high reset
//   Start       in   level; begin or restart the program at address 0
//   ImemData    in   9-bit instruction-memory read data for ImemAddr
//   BranchEn    in   decoder: current instruction is a branch
//   Taken       in   branch condition for the current instruction
//   Target      in   absolute branch target for the current instruction
//   Ack         in   decoder: current instruction is the halt word
//   ImemAddr    out  instruction-memory address (the PC)
//   Instruction out  ImemData while running, bubble 9'h180 otherwise
//   InstrValid  out  high exactly while running
//   Done        out  registered; high once halted
//   CycleCnt    out  saturating count of RUN cycles since the last Start
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [8:0]       ImemData,
   input  logic             BranchEn,
   input  logic             Taken,
   input  logic [PC_W-1:0]  Target,
   input  logic             Ack,
   output logic [PC_W-1:0]  ImemAddr,
   output logic [8:0]       Instruction,
   output logic             InstrValid,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCnt
);

   // Decodes to no write, no branch, no move, no load and no Ack.
   localparam logic [8:0] Bubble = 9'h180;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;

   logic [CNT_W-1:0]   cnt_inc;
   logic               cnt_sat;

   assign cnt_sat = (cnt_q == {CNT_W{1'b1}});
   assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      done_d  = done_q;

      unique case (state_q)
         StIdle: begin
            pc_d = '0;
            if (Start) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end

         StRun: begin
            // Every RUN edge counts, including the one that halts.
            cnt_d = cnt_inc;
            // The halt word also raises BranchEn, so Ack must win.
            if (Ack) begin
               state_d = StHalt;
               done_d  = 1'b1;
            end else if (BranchEn && Taken) begin
               pc_d = Target;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end

         StHalt: begin
            if (Start) begin
               state_d = StRun;
               pc_d    = '0;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end

         default: begin
            state_d = StIdle;
            pc_d    = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from state so Reset shows the bubble without a clock edge
   // ---------------------------------------------------------------------------
   always_comb begin
      InstrValid  = (state_q == StRun);
      Instruction = InstrValid ? ImemData : Bubble;
   end

   assign ImemAddr = pc_q;
   assign Done     = done_q;
   assign CycleCnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   total = 0;
   int   bad   = 0;

   // Main instance: PC_W=10, CNT_W=16
   logic        start;
   logic [8:0]  imem [0:1023];
   logic        brk  [0:1023];
   logic        taken;
   logic [9:0]  target;
   logic [9:0]  addr;
   logic [8:0]  instr;
   logic        valid, done;
   logic [15:0] cnt;
   logic [8:0]  rdata;
   logic        ack, br_en;

   assign rdata = imem[addr];
   assign ack   = (instr == 9'h1FF);
   assign br_en = ack || (valid && brk[addr]);

   instr_fetch #(.PC_W(10), .CNT_W(16)) u_dut (
      .Clk(clk), .Reset(rst), .Start(start), .ImemData(rdata),
      .BranchEn(br_en), .Taken(taken), .Target(target), .Ack(ack),
      .ImemAddr(addr), .Instruction(instr), .InstrValid(valid),
      .Done(done), .CycleCnt(cnt)
   );

   // Wrap instance: PC_W=4, straight-line code
   logic        start_w;
   logic [8:0]  imem_w [0:15];
   logic [3:0]  addr_w;
   logic [8:0]  instr_w, rdata_w;
   logic        valid_w, done_w, ack_w, taken_w;
   logic [3:0]  target_w;
   logic [15:0] cnt_w;

   assign rdata_w  = imem_w[addr_w];
   assign ack_w    = (instr_w == 9'h1FF);
   assign taken_w  = 1'b0;
   assign target_w = 4'd0;

   instr_fetch #(.PC_W(4), .CNT_W(16)) u_wrap (
      .Clk(clk), .Reset(rst), .Start(start_w), .ImemData(rdata_w),
      .BranchEn(ack_w), .Taken(taken_w), .Target(target_w), .Ack(ack_w),
      .ImemAddr(addr_w), .Instruction(instr_w), .InstrValid(valid_w),
      .Done(done_w), .CycleCnt(cnt_w)
   );

   // Saturation instance: CNT_W=4, loop 0..3 via taken branch at address 3
   logic        start_c;
   logic [9:0]  addr_c, target_c;
   logic [8:0]  instr_c, rdata_c;
   logic        valid_c, done_c, ack_c, br_en_c, taken_c;
   logic [3:0]  cnt_c;

   assign rdata_c  = 9'h000;
   assign ack_c    = (instr_c == 9'h1FF);
   assign br_en_c  = valid_c && (addr_c == 10'd3);
   assign taken_c  = 1'b1;
   assign target_c = 10'd0;

   instr_fetch #(.PC_W(10), .CNT_W(4)) u_sat (
      .Clk(clk), .Reset(rst), .Start(start_c), .ImemData(rdata_c),
      .BranchEn(br_en_c), .Taken(taken_c), .Target(target_c), .Ack(ack_c),
      .ImemAddr(addr_c), .Instruction(instr_c), .InstrValid(valid_c),
      .Done(done_c), .CycleCnt(cnt_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".addr"},  32'(addr),  32'd0);
      chk({tag, ".instr"}, 32'(instr), 32'h180);
      chk({tag, ".valid"}, 32'(valid), 32'd0);
      chk({tag, ".done"},  32'(done),  32'd0);
      chk({tag, ".cnt"},   32'(cnt),   32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      start_w = 1'b0;
      start_c = 1'b0;
      taken   = 1'b0;
      target  = 10'd0;
      for (int i = 0; i < 1024; i++) begin
         imem[i] = 9'h000;
         brk[i]  = 1'b0;
      end
      for (int i = 0; i < 16; i++) imem_w[i] = 9'h000;

      // Reset values, then 5 idle cycles with Start low
      #1;
      chk_idle("reset");
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_idle("idle");
      end

      // Straight-line program ending in the halt word
      imem[0] = 9'h000; imem[1] = 9'h040; imem[2] = 9'h080; imem[3] = 9'h1FF;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("seq.i0", 32'(instr), 32'h000);
      chk("seq.v0", 32'(valid), 32'd1);
      step(); chk("seq.i1", 32'(instr), 32'h040);
      step(); chk("seq.i2", 32'(instr), 32'h080);
      step(); chk("seq.i3", 32'(instr), 32'h1FF);
      step();
      chk("halt.done",  32'(done),  32'd1);
      chk("halt.addr",  32'(addr),  32'd3);
      chk("halt.cnt",   32'(cnt),   32'd4);
      chk("halt.instr", 32'(instr), 32'h180);
      chk("halt.valid", 32'(valid), 32'd0);
      step(); step();
      chk("hold.done",  32'(done),  32'd1);
      chk("hold.addr",  32'(addr),  32'd3);
      chk("hold.cnt",   32'(cnt),   32'd4);
      chk("hold.instr", 32'(instr), 32'h180);

      // Taken branch at 2 -> 7, restart from HALT
      imem[2] = 9'h0C0; imem[7] = 9'h1FF; brk[2] = 1'b1;
      taken = 1'b1; target = 10'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rst.done",  32'(done),  32'd0);
      chk("rst.addr",  32'(addr),  32'd0);
      chk("rst.cnt",   32'(cnt),   32'd0);
      chk("rst.valid", 32'(valid), 32'd1);
      step(); chk("bt.a1", 32'(addr), 32'd1);
      step(); chk("bt.a2", 32'(addr), 32'd2);
      step(); chk("bt.a7", 32'(addr), 32'd7);
      chk("bt.i7", 32'(instr), 32'h1FF);
      step();
      chk("bt.done", 32'(done), 32'd1);
      chk("bt.addr", 32'(addr), 32'd7);
      chk("bt.cnt",  32'(cnt),  32'd4);

      // Same program, branch not taken: fall through to the halt at 3
      taken = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("bn.a0", 32'(addr), 32'd0);
      step(); chk("bn.a1", 32'(addr), 32'd1);
      step(); chk("bn.a2", 32'(addr), 32'd2);
      step(); chk("bn.a3", 32'(addr), 32'd3);
      step();
      chk("bn.done", 32'(done), 32'd1);
      chk("bn.addr", 32'(addr), 32'd3);
      chk("bn.cnt",  32'(cnt),  32'd4);

      // Reset mid-RUN at PC=5
      imem[3] = 9'h000; imem[7] = 9'h000; brk[2] = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("mid.addr5", 32'(addr), 32'd5);
      chk("mid.cnt5",  32'(cnt),  32'd5);
      rst = 1'b1;
      #1;
      chk_idle("async");
      @(negedge clk);
      rst = 1'b0;
      chk_idle("post_rst");
      start = 1'b1;
      step();
      start = 1'b0;
      chk("re.a0", 32'(addr),  32'd0);
      chk("re.v",  32'(valid), 32'd1);
      step();
      chk("re.a1", 32'(addr), 32'd1);
      chk("re.c1", 32'(cnt),  32'd1);

      // PC_W=4 wrap; halt word appears at address 1 only on the second pass
      start_w = 1'b1;
      step();
      start_w = 1'b0;
      chk("wr.a0", 32'(addr_w), 32'd0);
      for (int i = 1; i < 16; i++) begin
         step();
         if (i == 2) imem_w[1] = 9'h1FF;
      end
      chk("wr.a15", 32'(addr_w), 32'd15);
      step(); chk("wr.wrap", 32'(addr_w), 32'd0);
      chk("wr.done0", 32'(done_w), 32'd0);
      step(); chk("wr.a1",   32'(addr_w), 32'd1);
      chk("wr.i1", 32'(instr_w), 32'h1FF);
      step();
      chk("wr.done", 32'(done_w), 32'd1);
      chk("wr.addr", 32'(addr_w), 32'd1);
      chk("wr.cnt",  32'(cnt_w),  32'd18);

      // CNT_W=4 saturation in a 4-instruction loop
      start_c = 1'b1;
      step();
      start_c = 1'b0;
      for (int i = 0; i < 14; i++) step();
      chk("sat.c14", 32'(cnt_c), 32'd14);
      step();
      chk("sat.c15", 32'(cnt_c), 32'd15);
      for (int i = 0; i < 5; i++) step();
      chk("sat.hold", 32'(cnt_c),   32'd15);
      chk("sat.addr", 32'(addr_c),  32'd0);
      chk("sat.v",    32'(valid_c), 32'd1);
      chk("sat.done", 32'(done_c),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and sequencing unit that produces the 9-bit instruction stream consumed by the control decoder. It owns the program counter, drives the instruction-memory address, presents each fetched instruction (or a bubble) to the decoder, and redirects or stops on the decoder's BranchEn and Ack outputs. It sits between instruction memory and the decoder, at the top of the CPU datapath. It also keeps a run-cycle counter for the test harness.

## Interface

- PC_W, 10: program counter / instruction-memory address width.
- CNT_W, 16: run-cycle counter width.
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  level; begin or restart the program at address 0.
- ImemData  input  9  instruction-memory read data for ImemAddr (combinational read).
- BranchEn  input  1  from decoder; current instruction is a branch.
- Taken  input  1  branch condition from ALU/flags for the current instruction.
- Target  input  PC_W  absolute branch target (from target LUT) for the current instruction.
- Ack  input  1  from decoder; current instruction is the halt word 9'h1FF.
- ImemAddr  output  PC_W  equals PC.
- Instruction  output  9  to decoder: ImemData in RUN, bubble 9'h180 otherwise.
- InstrValid  output  1  high exactly in RUN.
- Done  output  1  registered; high in HALT.
- CycleCnt  output  CNT_W  number of RUN cycles since the last Start.

## Operation

- States: IDLE, RUN, HALT (2-bit encoding, implementer's choice).
- Reset (async, any time including mid-RUN): state IDLE, PC 0, CycleCnt 0, Done 0. Instruction shows the bubble and InstrValid is 0 immediately, without waiting for a clock edge.
- Bubble 9'h180 decodes to no register write, no memory write, no branch, no move, no load, and no Ack. It is the only non-RUN value of Instruction.
- IDLE: PC held at 0. Start=1 at an edge moves to RUN and clears CycleCnt to 0.
- RUN, per edge, in priority order:
  1. Ack=1: go to HALT, PC holds (stays at the halt word's address), Done becomes 1.
  2. BranchEn=1 and Taken=1: PC <= Target.
  3. Otherwise: PC <= PC+1, wrapping modulo 2^PC_W (all-ones wraps to 0).
- Ack has priority over branch. The halt word also asserts BranchEn, so this ordering is required.
- BranchEn=1 with Taken=0 falls through to PC+1.
- Start is ignored in RUN.
- CycleCnt increments by 1 on every RUN edge, including the halting edge. It saturates at all-ones and does not wrap.
- HALT: PC and CycleCnt hold, Done stays 1. Start=1 at an edge causes all of the following together: PC <= 0, CycleCnt <= 0, Done <= 0, state RUN.
- No other transitions. HALT does not return to IDLE except by Reset.

## Timing

- Start sampled high at edge k: RUN from edge k, and the decoder sees ImemData at address 0 during cycle k..k+1.
- Fetch latency is zero. Instruction at PC is valid in the same cycle PC is presented, because memory read is combinational.
- Branch redirect takes effect at the next edge with no delay slot. The instruction at Target is presented in the following cycle.
- Halt word presented in cycle n: at edge n, Done rises, InstrValid falls, and Instruction becomes the bubble.
- A program of N instructions ending in the halt word, with no branches, gives CycleCnt = N.
- BranchEn, Taken, Target, and Ack are sampled only in RUN. They are don't-care elsewhere.

## Test plan

- Reset then hold Start=0 for 5 cycles: ImemAddr=0, Instruction=9'h180, InstrValid=0, Done=0, CycleCnt=0 throughout.
- Program 9'h000, 9'h040, 9'h080, 9'h1FF at addresses 0..3; Start pulsed one cycle: Instruction sequence 000, 040, 080, 1FF, then Done=1, ImemAddr=3, CycleCnt=4, Instruction=9'h180 held.
- Branch at address 2 with Taken=1, Target=7, and halt word at 7: ImemAddr sequence 0, 1, 2, 7, then halt with CycleCnt=4. Repeat with Taken=0: sequence 0, 1, 2, 3.
- PC_W=4, straight-line code from 0 with the halt word placed at address 1 of the second pass: ImemAddr wraps 15 -> 0, and the halt is reached after 18 RUN cycles (CycleCnt=18).
- Assert Reset mid-RUN at PC=5 for one cycle: outputs return immediately to IDLE values; the next Start restarts from address 0.
- After HALT, assert Start: Done drops at that edge, PC=0, CycleCnt restarts from 0. Separately, run a long loop with CNT_W=4: CycleCnt stops at 15.
